// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
// ----------------
// Shares the single vga_adapter plot port among three pixel requesters
// (0: init_screen, 1: game_plot, 2: score/game-over overlay writer).
// A requester raises req[i] and holds it for its whole burst. Once it is
// granted, every cycle with plot[i] & gnt[i] high is an accepted pixel.
// Accepted pixels are registered toward the adapter with one cycle of latency.
//
// Parameters
//   ROUND_ROBIN  0: fixed priority 0 > 1 > 2
//                1: rotating priority, search starts after the last owner
//   MAX_BURST    accepted-pixel limit per grant while another requester
//                is waiting; 0 means unlimited
//
// Ports
//   CLOCK_50              in   system clock
//   rst_n                 in   synchronous, active-low reset
//   req[2:0]              in   per-requester ownership request
//   plot[2:0]             in   per-requester pixel valid
//   x0..x2 / y0..y2 / c0..c2  in   per-requester pixel x (8b), y (7b), colour (3b)
//   gnt[2:0]              out  registered grant, one-hot or zero
//   owner[1:0]            out  current owner index, 3 when none
//   busy                  out  high while a grant is held
//   vga_plot/x/y/colour   out  registered pixel toward vga_adapter
module vga_plot_arbiter #(
    parameter int          ROUND_ROBIN = 0,
    parameter logic [15:0] MAX_BURST   = 16'd0
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] plot,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    input  logic [2:0] c2,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  gnt_nxt;
    logic [1:0]  owner_nxt;
    logic [1:0]  last_owner, last_owner_nxt;
    logic [15:0] burst_cnt, burst_cnt_nxt;

    logic [1:0]  search_start;
    logic [1:0]  winner;
    logic        accept_p0;
    logic        owner_req;
    logic        others_waiting;
    logic        burst_full;
    logic [7:0]  x_p0;
    logic [6:0]  y_p0;
    logic [2:0]  c_p0;

    // First requester found walking start, start+1, start+2 (mod 3);
    // 3 when no request is raised.
    function automatic logic [1:0] pick_winner(input logic [2:0] r,
                                               input logic [1:0] start);
        int idx;
        pick_winner = 2'd3;
        // Walk backwards so the earliest position in the search order wins.
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(start) + k) % 3;
            if (r[idx]) pick_winner = idx[1:0];
        end
    endfunction

    // Saturating increment: the counter never wraps back through zero.
    function automatic logic [15:0] burst_inc(input logic [15:0] cnt);
        burst_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_comb begin
        if (ROUND_ROBIN != 0)
            search_start = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
        else
            search_start = 2'd0;
    end

    assign winner         = pick_winner(req, search_start);
    // gnt is one-hot or zero, so these reduce to the owner's own signals.
    assign accept_p0      = |(plot & gnt);
    assign owner_req      = |(req & gnt);
    assign others_waiting = |(req & ~gnt);
    assign burst_full     = (MAX_BURST != 16'd0) && (burst_inc(burst_cnt) == MAX_BURST);
    assign busy           = (state == OWN);

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt     = OWN;
                    gnt_nxt       = 3'b001 << winner;
                    owner_nxt     = winner;
                    burst_cnt_nxt = 16'd0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_nxt      = IDLE;
                    gnt_nxt        = 3'b000;
                    owner_nxt      = 2'd3;
                    last_owner_nxt = owner;
                end else if (accept_p0) begin
                    if (burst_full) begin
                        if (others_waiting) begin
                            state_nxt      = IDLE;
                            gnt_nxt        = 3'b000;
                            owner_nxt      = 2'd3;
                            last_owner_nxt = owner;
                        end else begin
                            // Nobody waiting: start a fresh burst, keep the grant.
                            burst_cnt_nxt = 16'd0;
                        end
                    end else begin
                        burst_cnt_nxt = burst_inc(burst_cnt);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 3'b000;
                owner_nxt = 2'd3;
            end
        endcase
    end

    always_comb begin
        case (owner)
            2'd0:    begin x_p0 = x0; y_p0 = y0; c_p0 = c0; end
            2'd1:    begin x_p0 = x1; y_p0 = y1; c_p0 = c1; end
            2'd2:    begin x_p0 = x2; y_p0 = y2; c_p0 = c2; end
            default: begin x_p0 = 8'd0; y_p0 = 7'd0; c_p0 = 3'd0; end
        endcase
    end

    // Stage boundary: arbitration state and accepted pixel -> adapter register
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= 3'b000;
            owner      <= 2'd3;
            last_owner <= 2'd2;
            burst_cnt  <= 16'd0;
            vga_plot   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            vga_plot   <= accept_p0;
            if (accept_p0) begin
                vga_x      <= x_p0;
                vga_y      <= y_p0;
                vga_colour <= c_p0;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
module tb_vga_plot_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic [2:0] req, plot;
    logic [7:0] x0, x1, x2;
    logic [6:0] y0, y1, y2;
    logic [2:0] c0, c1, c2;

    logic [2:0] gnt_a, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b, vp_a, vp_b;
    logic [7:0] vx_a, vx_b;
    logic [6:0] vy_a, vy_b;
    logic [2:0] vc_a, vc_b;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_plot_arbiter #(.ROUND_ROBIN(0), .MAX_BURST(16'd0)) dut_a (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .req(req), .plot(plot),
        .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
        .c0(c0), .c1(c1), .c2(c2),
        .gnt(gnt_a), .owner(owner_a), .busy(busy_a),
        .vga_plot(vp_a), .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a));

    vga_plot_arbiter #(.ROUND_ROBIN(1), .MAX_BURST(16'd4)) dut_b (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .req(req), .plot(plot),
        .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
        .c0(c0), .c1(c1), .c2(c2),
        .gnt(gnt_b), .owner(owner_b), .busy(busy_b),
        .vga_plot(vp_b), .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b));

    // Reference model: index 0 mirrors dut_a (fixed, unlimited), 1 mirrors dut_b.
    int m_own[2]  = '{-1, -1};
    int m_last[2] = '{2, 2};
    int m_cnt[2]  = '{0, 0};
    int m_rr[2]   = '{0, 1};
    int m_mb[2]   = '{0, 4};
    logic [17:0] q_a[$];
    logic [17:0] q_b[$];

    function automatic logic [17:0] pixel_of(input int i);
        case (i)
            0:       return {x0, y0, c0};
            1:       return {x1, y1, c1};
            default: return {x2, y2, c2};
        endcase
    endfunction

    task automatic model_step(input int k);
        bit acc;
        int start, w;
        if (!rst_n) begin
            m_own[k] = -1; m_last[k] = 2; m_cnt[k] = 0;
        end else if (m_own[k] < 0) begin
            if (req != 3'b000) begin
                start = (m_rr[k] != 0) ? (m_last[k] + 1) % 3 : 0;
                w = -1;
                for (int j = 0; j < 3; j++)
                    if (w < 0 && req[(start + j) % 3]) w = (start + j) % 3;
                m_own[k] = w;
                m_cnt[k] = 0;
            end
        end else begin
            acc = plot[m_own[k]];
            if (acc) begin
                if (k == 0) q_a.push_back(pixel_of(m_own[k]));
                else        q_b.push_back(pixel_of(m_own[k]));
            end
            if (!req[m_own[k]]) begin
                m_last[k] = m_own[k]; m_own[k] = -1;
            end else if (acc) begin
                m_cnt[k]++;
                if (m_mb[k] != 0 && m_cnt[k] == m_mb[k]) begin
                    if ((req & ~(3'b001 << m_own[k])) != 3'b000) begin
                        m_last[k] = m_own[k]; m_own[k] = -1;
                    end else begin
                        m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    always @(posedge CLOCK_50) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor_dut(input int k, input logic [2:0] g, input logic [1:0] o,
                               input logic b, input logic vp, input logic [17:0] pix);
        logic [2:0]  eg;
        logic        has;
        logic [17:0] e;
        eg = (m_own[k] < 0) ? 3'b000 : 3'(1 << m_own[k]);
        check($sformatf("gnt[%0d]", k), 32'(g), 32'(eg));
        check($sformatf("owner[%0d]", k), 32'(o), (m_own[k] < 0) ? 32'd3 : 32'(m_own[k]));
        check($sformatf("busy[%0d]", k), 32'(b), 32'(m_own[k] >= 0));
        has = 1'b0;
        e   = '0;
        if (k == 0) begin
            if (q_a.size() > 0) begin has = 1'b1; e = q_a.pop_front(); end
        end else begin
            if (q_b.size() > 0) begin has = 1'b1; e = q_b.pop_front(); end
        end
        check($sformatf("vga_plot[%0d]", k), 32'(vp), 32'(has));
        if (has && vp === 1'b1)
            check($sformatf("vga_pixel[%0d]", k), 32'(pix), 32'(e));
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            monitor_dut(0, gnt_a, owner_a, busy_a, vp_a, {vx_a, vy_a, vc_a});
            monitor_dut(1, gnt_b, owner_b, busy_b, vp_b, {vx_b, vy_b, vc_b});
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 3'b000; plot = 3'b000;
        x0 = '0; x1 = '0; x2 = '0; y0 = '0; y1 = '0; y2 = '0;
        c0 = '0; c1 = '0; c2 = '0;
        tick();
        mon_en = 1;
        tick();
        tick();
        check("rst gnt_a", 32'(gnt_a), 32'd0);
        check("rst owner_a", 32'(owner_a), 32'd3);
        check("rst busy_a", 32'(busy_a), 32'd0);
        check("rst pixel_a", 32'({vp_a, vx_a, vy_a, vc_a}), 32'd0);
        check("rst owner_b", 32'(owner_b), 32'd3);
        check("rst pixel_b", 32'({vp_b, vx_b, vy_b, vc_b}), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single requester 1 with one pixel held.
        req = 3'b010; plot = 3'b010; x1 = 8'd10; y1 = 7'd20; c1 = 3'd4;
        tick();
        check("grant latency a", 32'(gnt_a), 32'b010);
        check("grant latency b", 32'(gnt_b), 32'b010);
        tick();
        check("first pixel plot", 32'(vp_a), 32'd1);
        check("first pixel x", 32'(vx_a), 32'd10);
        check("first pixel y", 32'(vy_a), 32'd20);
        check("first pixel colour", 32'(vc_a), 32'd4);
        req = 3'b000; plot = 3'b000;
        tick();
        tick();

        // Fixed priority with handover gap.
        req = 3'b111;
        tick();
        check("fixed prio first", 32'(gnt_a), 32'b001);
        req = 3'b110;
        tick();
        check("handover gap", 32'(gnt_a), 32'b000);
        tick();
        check("fixed prio second", 32'(gnt_a), 32'b010);
        req = 3'b000;
        tick();
        tick();

        // Randomized traffic, checked every cycle by the monitor.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i]) req[i] = ($urandom % 12) != 0;
                else        req[i] = ($urandom % 4) == 0;
                plot[i] = ($urandom % 4) != 0;
            end
            x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
            y0 = 7'($urandom); y1 = 7'($urandom); y2 = 7'($urandom);
            c0 = 3'($urandom); c1 = 3'($urandom); c2 = 3'($urandom);
            rst_n = ($urandom % 250) != 0;
            tick();
        end
        rst_n = 1'b1; req = 3'b000; plot = 3'b000;
        tick();
        tick();

        // Reset while requester 0 streams.
        req = 3'b001; plot = 3'b001;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midburst rst gnt", 32'(gnt_a), 32'd0);
        check("midburst rst plot", 32'(vp_a), 32'd0);
        check("midburst rst owner", 32'(owner_a), 32'd3);
        check("midburst rst plot b", 32'(vp_b), 32'd0);
        rst_n = 1'b1; req = 3'b111; plot = 3'b000;
        tick();
        check("post rst prio a", 32'(gnt_a), 32'b001);
        check("post rst prio b", 32'(gnt_b), 32'b001);
        req = 3'b000;
        tick();
        tick();
        tick();
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
